// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between mem_port_arbiter, the CPU pipeline (IF/MEM ports)
// and the unified memory.
//   slave  : the arbiter's view (serves I/D requests, drives the memory port)
//   master : the environment's view (pipeline requesters plus memory model)
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // instruction-fetch port
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_flush;
  logic              i_gnt;
  logic              i_resp_valid;
  logic [DATA_W-1:0] i_rdata;

  // data-access port
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_resp_valid;
  logic [DATA_W-1:0] d_rdata;

  // memory port
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  i_req, i_addr, i_flush,
    output i_gnt, i_resp_valid, i_rdata,
    input  d_req, d_we, d_addr, d_wdata,
    output d_gnt, d_resp_valid, d_rdata,
    output mem_req_valid, mem_we, mem_addr, mem_wdata,
    input  mem_req_ready, mem_resp_valid, mem_rdata
  );

  modport master (
    output i_req, i_addr, i_flush,
    input  i_gnt, i_resp_valid, i_rdata,
    output d_req, d_we, d_addr, d_wdata,
    input  d_gnt, d_resp_valid, d_rdata,
    input  mem_req_valid, mem_we, mem_addr, mem_wdata,
    output mem_req_ready, mem_resp_valid, mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported, multi-cycle memory between the fetch port (I)
// and the load/store port (D). D wins by default; a starvation counter hands
// the next arbitration to I after STARVE_LIMIT back-to-back D grants made
// while I was waiting. One memory transaction in flight at a time.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | arbitrate; grant latches the request and owner
// ISSUE | mem_req_valid high from latched registers until mem_req_ready
// WAIT  | waiting for mem_resp_valid; capture read data for the owner
// RESP  | one-cycle resp_valid pulse to the owner (I pulse may be flushed)
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input logic          clk,
  input logic          reset,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [3:0] LIMIT   = 4'(STARVE_LIMIT);
  localparam logic       OWNER_I = 1'b0;
  localparam logic       OWNER_D = 1'b1;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic [3:0]        starve_cnt_q, starve_cnt_d;
  logic              flushed_q, flushed_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  logic grant_i;
  logic grant_d;
  logic flush_hit;
  logic i_drop;

  // a flush only matters while I owns a transaction past its grant
  assign flush_hit = bus.i_flush && (owner_q == OWNER_I) && (state_q != S_IDLE);
  assign i_drop    = flushed_q || flush_hit;

  // IDLE arbitration: D by default, I once the starvation count saturates
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state_q == S_IDLE) begin
      if (bus.i_req && bus.d_req) begin
        if (starve_cnt_q == LIMIT) grant_i = 1'b1;
        else                       grant_d = 1'b1;
      end else if (bus.i_req) begin
        grant_i = 1'b1;
      end else if (bus.d_req) begin
        grant_d = 1'b1;
      end
    end
  end

  // next-state and register updates for the transaction sequencer
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    starve_cnt_d = starve_cnt_q;
    flushed_d    = flushed_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;

    case (state_q)
      S_IDLE: begin
        flushed_d = 1'b0;
        if (grant_i) begin
          owner_d      = OWNER_I;
          addr_d       = bus.i_addr;
          we_d         = 1'b0;
          wdata_d      = '0;
          starve_cnt_d = '0;
          state_d      = S_ISSUE;
        end else if (grant_d) begin
          owner_d = OWNER_D;
          addr_d  = bus.d_addr;
          we_d    = bus.d_we;
          wdata_d = bus.d_wdata;
          if (!bus.i_req)                starve_cnt_d = '0;
          else if (starve_cnt_q != LIMIT) starve_cnt_d = starve_cnt_q + 4'd1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        flushed_d = flushed_q || flush_hit;
        if (bus.mem_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        flushed_d = flushed_q || flush_hit;
        if (bus.mem_resp_valid) begin
          // a flushed fetch leaves i_rdata at the last delivered value
          if (owner_q == OWNER_D) d_rdata_d = we_q ? '0 : bus.mem_rdata;
          else if (!i_drop)       i_rdata_d = bus.mem_rdata;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        flushed_d = 1'b0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      owner_q      <= OWNER_I;
      starve_cnt_q <= '0;
      flushed_q    <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      starve_cnt_q <= starve_cnt_d;
      flushed_q    <= flushed_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  assign bus.i_gnt         = grant_i;
  assign bus.d_gnt         = grant_d;
  assign bus.mem_req_valid = (state_q == S_ISSUE);
  assign bus.mem_we        = we_q;
  assign bus.mem_addr      = addr_q;
  assign bus.mem_wdata     = wdata_q;
  assign bus.i_resp_valid  = (state_q == S_RESP) && (owner_q == OWNER_I) && !i_drop;
  assign bus.d_resp_valid  = (state_q == S_RESP) && (owner_q == OWNER_D);
  assign bus.i_rdata       = i_rdata_q;
  assign bus.d_rdata       = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: transaction-timeline reference model
// with a scoreboard of expected responses and an independent response monitor.
module tb_mem_port_arbiter;
  localparam int ADDR_W       = 32;
  localparam int DATA_W       = 32;
  localparam int STARVE_LIMIT = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct { bit port_d; logic [31:0] data; int cyc; } exp_t;
  typedef struct { int s; int l; logic [31:0] addr; bit we; logic [31:0] wdata; } mreq_t;

  exp_t        sb_q[$];
  mreq_t       devq[$];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] dev_mem [logic [31:0]];

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // requester and model state
  bit          ip = 0, dp = 0, dwe = 0;
  logic [31:0] ia = '0, da = '0, dw = '0;
  int free_at = 0, iss_lo = 1, iss_hi = 0, starve = 0;
  int iwin_lo = 1, iwin_hi = 0, flush_cyc = -1;
  // memory device state
  int          dev_cnt = 0, resp_cyc = -1;
  bit          dev_out = 0;
  logic [31:0] resp_data = '0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] init_val(logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h0000_5A5A;
  endfunction

  function automatic logic [31:0] rd_ref(logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  function automatic logic [31:0] rd_dev(logic [31:0] a);
    return dev_mem.exists(a) ? dev_mem[a] : init_val(a);
  endfunction

  // response monitor: every resp_valid pulse must match the scoreboard head
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (bus.i_resp_valid === 1'b1 || bus.d_resp_valid === 1'b1) begin
      check("resp_onehot", 64'(bus.i_resp_valid & bus.d_resp_valid), 64'd0);
      if (sb_q.size() == 0) begin
        check("resp_unexpected", {bus.i_resp_valid, bus.d_resp_valid}, 64'd0);
      end else begin
        e = sb_q.pop_front();
        check("resp_port_d", 64'(bus.d_resp_valid), 64'(e.port_d));
        check("resp_data", bus.d_resp_valid ? bus.d_rdata : bus.i_rdata, e.data);
        check("resp_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // one clock of model prediction, memory device and requester stimulus
  task automatic step(int p_req, int max_s, int max_l);
    bit    exp_i, exp_d;
    int    g, a, r, x;
    mreq_t m;
    @(negedge clk);
    exp_i = 0;
    exp_d = 0;
    if (cyc >= free_at && (ip || dp)) begin
      if (ip && dp) begin
        if (starve >= STARVE_LIMIT) exp_i = 1;
        else                        exp_d = 1;
      end else if (ip) exp_i = 1;
      else             exp_d = 1;
    end
    check("i_gnt", 64'(bus.i_gnt), 64'(exp_i));
    check("d_gnt", 64'(bus.d_gnt), 64'(exp_d));
    check("mem_req_valid", 64'(bus.mem_req_valid), 64'(cyc >= iss_lo && cyc <= iss_hi));

    if (exp_i || exp_d) begin
      g   = cyc;
      m.s = int'($urandom_range(max_s, 0));
      m.l = int'($urandom_range(max_l, 1));
      a   = g + 1 + m.s;
      r   = a + m.l + 1;
      iss_lo  = g + 1;
      iss_hi  = a;
      free_at = r + 1;
      if (exp_d) begin
        starve  = ip ? ((starve < STARVE_LIMIT) ? starve + 1 : starve) : 0;
        m.addr  = da;
        m.we    = dwe;
        m.wdata = dw;
        if (dwe) begin
          ref_mem[da] = dw;
          sb_q.push_back('{1'b1, 32'h0, r});
        end else begin
          sb_q.push_back('{1'b1, rd_ref(da), r});
        end
      end else begin
        starve  = 0;
        m.addr  = ia;
        m.we    = 1'b0;
        m.wdata = '0;
        iwin_lo = g + 1;
        iwin_hi = r;
        flush_cyc = ($urandom_range(2, 0) == 0) ? int'($urandom_range(r, g + 1)) : -1;
        if (flush_cyc < 0) sb_q.push_back('{1'b0, rd_ref(ia), r});
      end
      devq.push_back(m);
    end

    if (bus.mem_req_valid === 1'b1 && devq.size() > 0) begin
      m = devq[0];
      check("mem_addr", bus.mem_addr, m.addr);
      check("mem_we", 64'(bus.mem_we), 64'(m.we));
      if (m.we) check("mem_wdata", bus.mem_wdata, m.wdata);
      if (bus.mem_req_ready) begin
        void'(devq.pop_front());
        if (bus.mem_we) begin
          dev_mem[bus.mem_addr] = bus.mem_wdata;
          resp_data = $urandom;
        end else begin
          resp_data = rd_dev(bus.mem_addr);
        end
        resp_cyc = cyc + m.l;
        dev_out  = 1;
        dev_cnt  = 0;
      end else begin
        dev_cnt++;
      end
    end
    if (cyc == resp_cyc) dev_out = 0;

    @(posedge clk);
    #1;
    x = cyc;
    if (exp_i) ip = 0;
    if (exp_d) dp = 0;
    if (!ip && int'($urandom_range(99, 0)) < p_req) begin
      ip = 1;
      ia = 32'($urandom_range(15, 0)) << 2;
    end
    if (!dp && int'($urandom_range(99, 0)) < p_req) begin
      dp  = 1;
      da  = 32'($urandom_range(15, 0)) << 2;
      dwe = 1'($urandom_range(1, 0));
      dw  = $urandom;
    end
    bus.i_req   = ip;
    bus.i_addr  = ip ? ia : $urandom;
    bus.d_req   = dp;
    bus.d_we    = dp ? dwe : 1'($urandom_range(1, 0));
    bus.d_addr  = dp ? da : $urandom;
    bus.d_wdata = dp ? dw : $urandom;
    bus.i_flush = (x >= iwin_lo && x <= iwin_hi) ? (x == flush_cyc) : ($urandom_range(7, 0) == 0);
    bus.mem_req_ready = (devq.size() > 0) ? (dev_cnt >= devq[0].s) : 1'b0;
    if (x == resp_cyc) begin
      bus.mem_resp_valid = 1'b1;
      bus.mem_rdata      = resp_data;
    end else if (!dev_out && $urandom_range(15, 0) == 0) begin
      bus.mem_resp_valid = 1'b1;
      bus.mem_rdata      = $urandom;
    end else begin
      bus.mem_resp_valid = 1'b0;
      bus.mem_rdata      = $urandom;
    end
  endtask

  task automatic run(int n, int p_req, int max_s, int max_l);
    for (int k = 0; k < n; k++) step(p_req, max_s, max_l);
  endtask

  task automatic check_outputs_zero(string tag);
    check({tag, "_i_gnt"}, 64'(bus.i_gnt), 64'd0);
    check({tag, "_d_gnt"}, 64'(bus.d_gnt), 64'd0);
    check({tag, "_i_resp_valid"}, 64'(bus.i_resp_valid), 64'd0);
    check({tag, "_d_resp_valid"}, 64'(bus.d_resp_valid), 64'd0);
    check({tag, "_i_rdata"}, bus.i_rdata, 64'd0);
    check({tag, "_d_rdata"}, bus.d_rdata, 64'd0);
    check({tag, "_mem_req_valid"}, 64'(bus.mem_req_valid), 64'd0);
    check({tag, "_mem_we"}, 64'(bus.mem_we), 64'd0);
    check({tag, "_mem_addr"}, bus.mem_addr, 64'd0);
    check({tag, "_mem_wdata"}, bus.mem_wdata, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout at cycle %0d, required run completion", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    bus.i_req = 0; bus.i_addr = '0; bus.i_flush = 0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.mem_req_ready = 0; bus.mem_resp_valid = 0; bus.mem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;

    run(60, 100, 0, 1);   // both ports saturated, minimum memory latency
    run(800, 40, 3, 3);
    run(300, 15, 2, 4);
    run(60, 0, 3, 3);     // drain outstanding requests
    check("sb_drain", 64'(sb_q.size()), 64'd0);

    // reset in WAIT, late memory response must be ignored
    bus.i_req = 0; bus.i_flush = 0; bus.mem_resp_valid = 0;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h40; bus.mem_req_ready = 1;
    @(negedge clk);
    check("rst_t0_d_gnt", 64'(bus.d_gnt), 64'd1);
    @(posedge clk); #1;
    bus.d_req = 0;
    @(negedge clk);
    check("rst_t1_mem_req_valid", 64'(bus.mem_req_valid), 64'd1);
    check("rst_t1_mem_addr", bus.mem_addr, 64'h40);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = 32'hDEADBEEF;
    @(negedge clk);
    check_outputs_zero("post_rst");
    @(posedge clk); #1;
    bus.mem_resp_valid = 1'b0;
    @(negedge clk);
    check("post_rst_no_resp", {bus.i_resp_valid, bus.d_resp_valid}, 64'd0);
    check("post_rst_mem_req_valid", 64'(bus.mem_req_valid), 64'd0);

    // lone fetch after reset: data back three cycles after the grant
    @(posedge clk); #1;
    bus.i_req  = 1;
    bus.i_addr = 32'h0;
    @(negedge clk);
    check("fetch_i_gnt", 64'(bus.i_gnt), 64'd1);
    check("fetch_d_gnt", 64'(bus.d_gnt), 64'd0);
    sb_q.push_back('{1'b0, 32'h0000_0013, cyc + 3});
    @(posedge clk); #1;
    bus.i_req = 0;
    @(posedge clk); #1;
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = 32'h0000_0013;
    @(posedge clk); #1;
    bus.mem_resp_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("fetch_sb_empty", 64'(sb_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, multi-cycle unified memory between the pipeline's instruction-fetch port (I, read-only) and its data-access port (D, load/store).
- Sits between the IF/MEM stages and the memory model. The CPU uses the not-yet-granted and not-yet-responded conditions of each port as stall sources.
- Default priority goes to D, because it carries the older instruction. A starvation counter guarantees forward progress for I.
- Only one memory transaction is in flight at a time.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- STARVE_LIMIT, 4, number of consecutive D grants made while I is waiting, after which I wins the next arbitration. Legal range 1..15.

Ports:
- clk  input  1  clock, all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- i_req  input  1  fetch request; held until i_gnt
- i_addr  input  ADDR_W  fetch address; stable while i_req is high
- i_flush  input  1  discard any outstanding I response (branch redirect)
- i_gnt  output  1  I request accepted this cycle
- i_resp_valid  output  1  one-cycle pulse, i_rdata valid
- i_rdata  output  DATA_W  fetched word
- d_req  input  1  data request; held until d_gnt
- d_we  input  1  1 = store, 0 = load
- d_addr  input  ADDR_W  data address
- d_wdata  input  DATA_W  store data
- d_gnt  output  1  D request accepted this cycle
- d_resp_valid  output  1  one-cycle pulse, load data valid or store acknowledged
- d_rdata  output  DATA_W  load data; 0 for stores
- mem_req_valid  output  1  request to memory
- mem_req_ready  input  1  memory accepts the request
- mem_we  output  1  write enable
- mem_addr  output  ADDR_W  address
- mem_wdata  output  DATA_W  write data
- mem_resp_valid  input  1  memory completion pulse (reads and writes)
- mem_rdata  input  DATA_W  read data; valid with mem_resp_valid

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, RESP. Owner register: 0 = I, 1 = D.
- Reset values: state IDLE, owner 0, starve_cnt 0, flushed 0.
- Reset values of outputs: all mem_* outputs 0, i_gnt/d_gnt 0, both resp_valid 0, both rdata 0.
- IDLE arbitration: gnt is combinational from state and the req inputs. Exactly one of i_gnt/d_gnt is high, and only in IDLE.
  - Both requesting and starve_cnt < STARVE_LIMIT: D wins.
  - Both requesting and starve_cnt == STARVE_LIMIT: I wins.
  - Only one requesting: that port wins.
- On a grant: latch addr, we, wdata and owner, and go to ISSUE. For I grants, mem_we is latched as 0.
- starve_cnt update at each IDLE grant:
  - increments if D is granted while i_req is high;
  - clears if I is granted, or if i_req is low;
  - saturates at STARVE_LIMIT.
- ISSUE: mem_req_valid = 1, driven from the latched registers. Go to WAIT on mem_req_ready; otherwise hold with all mem_* outputs stable.
- WAIT: mem_req_valid = 0. On mem_resp_valid, latch mem_rdata into the owner's rdata register (D store: latch 0) and go to RESP.
- RESP: pulse the owner's resp_valid for exactly one cycle, then go to IDLE.
  - No arbitration happens in RESP.
  - Minimum grant-to-resp_valid latency is 3 cycles (memory responds in the cycle after acceptance).
  - Maximum request throughput is one transaction per 4 cycles.
- rdata registers hold their value until the next response to that port.
- i_flush handling:
  - In ISSUE, WAIT or RESP with owner = I, i_flush sets flushed. The memory transaction still completes, but i_resp_valid is suppressed (including in the same RESP cycle).
  - flushed clears on entry to IDLE.
  - In IDLE, i_flush has no effect on arbitration. A concurrent i_req is granted normally.
  - i_flush is ignored when owner = D.
- mem_resp_valid outside WAIT is ignored.
- Reset mid-transaction discards all state; a late mem_resp_valid then arrives in IDLE and is ignored.
- A requester keeping req high after resp_valid is treated as a new request.

Test Plan:
- Lone load, d_addr=0x40, memory returns 0xDEADBEEF one cycle after acceptance, ready=1 -> d_gnt at T0, mem_req_valid at T1, d_resp_valid with d_rdata=0xDEADBEEF at T3; i_* outputs stay quiet.
- i_req and d_req held high continuously, STARVE_LIMIT=4 -> grant order D,D,D,D,I,D,D,D,D,I; never two simultaneous gnts.
- Store, d_addr=0x10, d_wdata=0x12345678, mem_req_ready low for 3 cycles -> mem_addr/mem_wdata/mem_we=1 held stable for 4 cycles, d_resp_valid pulses once, d_rdata=0.
- I fetch 0x100 in flight, i_flush pulsed during WAIT -> no i_resp_valid, FSM returns to IDLE, a following i_req for 0x200 is granted and returns its data normally.
- reset asserted during WAIT, then mem_resp_valid arrives -> all outputs 0 the cycle after reset, no resp_valid pulse, next request proceeds normally.
- i_req alone, addr 0x0, mem_rdata 0x00000013 -> i_rdata=0x13 with i_resp_valid at T3, starve_cnt stays 0.
